pipe_stage_reg: RTL

//  Parametrised inter-stage pipeline register for the 5-stage MIPS core (D/E, E/M, M/W).

---
 rtl/pipe_stage_reg.sv | 92 +++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register for a 5-stage MIPS core (D/E, E/M, M/W).
// It carries the valid bit, instruction, PC, NUM_DATA data words and the control bundle.
// It supports stall (hold) and flush (insert a bubble).
// The Tnew field is presented saturating-decremented, so hazard logic sees the remaining latency.
// Ports:
//   i_clk, i_reset           clock; synchronous active-high reset
//   i_stall, i_flush         hold contents / load a bubble (flush wins over stall)
//   i_valid, i_ins, i_pc     incoming valid bit, instruction word, instruction PC
//   i_data                   NUM_DATA 32-bit words, word k at [32k+31:32k]
//   i_ctrl                   control bundle including the Tnew field
//   o_valid, o_ins, o_pc     registered valid, instruction, PC
//   o_data                   registered data words
//   o_ctrl                   registered control with the Tnew field decremented (saturating at 0)
module pipe_stage_reg #(
    parameter int          CTRL_W        = 31,
    parameter int          NUM_DATA      = 3,
    parameter int          TNEW_LSB      = 8,
    parameter int          TNEW_W        = 3,
    parameter int          TNEW_MODE     = 0,
    parameter logic [31:0] RESET_PC      = 32'h0000_3000,
    parameter int          FLUSH_KEEP_PC = 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_stall,
    input  logic                     i_flush,
    input  logic                     i_valid,
    input  logic [31:0]              i_ins,
    input  logic [31:0]              i_pc,
    input  logic [NUM_DATA*32-1:0]   i_data,
    input  logic [CTRL_W-1:0]        i_ctrl,
    output logic                     o_valid,
    output logic [31:0]              o_ins,
    output logic [31:0]              o_pc,
    output logic [NUM_DATA*32-1:0]   o_data,
    output logic [CTRL_W-1:0]        o_ctrl
);
    localparam int TH = TNEW_LSB + TNEW_W - 1;

    if (TNEW_LSB + TNEW_W > CTRL_W) begin : g_bad_tnew
        $error("pipe_stage_reg: Tnew field exceeds control bundle width");
    end

    logic                   r_valid = 1'b0;
    logic [31:0]            r_ins   = '0;
    logic [31:0]            r_pc    = RESET_PC;
    logic [NUM_DATA*32-1:0] r_data  = '0;
    logic [CTRL_W-1:0]      r_ctrl  = '0;
    logic [TNEW_W-1:0]      w_tnew;
    logic [TNEW_W-1:0]      w_tnew_dec;

    assign w_tnew     = r_ctrl[TH:TNEW_LSB];
    // Saturating decrement: a stage already producing its result never reports a negative latency.
    assign w_tnew_dec = (w_tnew == '0) ? '0 : w_tnew - TNEW_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_ins   <= '0;
            r_pc    <= RESET_PC;
            r_data  <= '0;
            r_ctrl  <= '0;
        end else if (i_flush) begin
            // A zero control bundle guarantees that the bubble has no side effects.
            r_valid <= 1'b0;
            r_ins   <= '0;
            r_pc    <= (FLUSH_KEEP_PC != 0) ? i_pc : RESET_PC;
            r_data  <= '0;
            r_ctrl  <= '0;
        end else if (i_stall) begin
            // In mode 1 the held instruction keeps ageing, so its Tnew counts down while stalled.
            if (TNEW_MODE == 1)
                r_ctrl[TH:TNEW_LSB] <= w_tnew_dec;
        end else begin
            r_valid <= i_valid;
            r_ins   <= i_ins;
            r_pc    <= i_pc;
            r_data  <= i_data;
            r_ctrl  <= i_ctrl;
        end
    end

    always_comb begin
        o_ctrl              = r_ctrl;
        o_ctrl[TH:TNEW_LSB] = w_tnew_dec;
    end

    assign o_valid = r_valid;
    assign o_ins   = r_ins;
    assign o_pc    = r_pc;
    assign o_data  = r_data;
endmodule
